global_mem_arbiter: RTL and testbench

- Shares the single global-memory port on the GPU card between NUM_REQ requesters. Port 0 is the host/CPU load-store path; port 1 is the gpu_die core.
- Grants requests round-robin and serializes them one at a time onto the memory controller's pulse-request / pulse-ack interface.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between gpu_die and the global memory controller inside gpu_card.

---
 rtl/global_mem_pkg.sv | 20 ++
 rtl/rr_select.sv | 29 ++
 rtl/global_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_global_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/global_mem_pkg.sv
// Shared types for the global-memory arbiter.
// FSM states, operation kinds and default widths.
package global_mem_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first pending index after last_grant.
// Purely combinational so other arbiters can reuse it.
module rr_select #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         pending,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int IW = $clog2(NUM_REQ);

    // Walk offsets from farthest to nearest so the nearest pending wins.
    always_comb begin
        logic [IW-1:0] j;
        valid = 1'b0;
        index = '0;
        j     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(last_grant) + k) % NUM_REQ);
            if (pending[j]) begin
                valid = 1'b1;
                index = j;
            end
        end
    end

endmodule

// File: rtl/global_mem_arbiter.sv
// Round-robin arbiter for the single global-memory port.
// Serialises one requester at a time onto pulse-req / pulse-ack.
module global_mem_arbiter
    import global_mem_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_rd_req,
    input  logic [NUM_REQ-1:0]            req_wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         req_rd_data,
    output logic                          mem_rd_req,
    output logic                          mem_wr_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    input  logic                          mem_ack,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state;
    op_e                   op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [IW-1:0]         last_grant;
    logic [CW-1:0]         cnt;

    logic [NUM_REQ-1:0]    pending;
    logic                  sel_valid;
    logic [IW-1:0]         sel_idx;
    logic                  sel_rd;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign pending   = req_rd_req | req_wr_req;
    assign sel_rd    = req_rd_req[sel_idx];
    assign sel_wr    = req_wr_req[sel_idx];
    assign sel_addr  = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wr_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign busy        = (state != IDLE);

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .pending   (pending),
        .last_grant(last_grant),
        .valid     (sel_valid),
        .index     (sel_idx)
    );

    // Transaction FSM; pulses and acks default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            grant_idx   <= '0;
            cnt         <= '0;
            req_ack     <= '0;
            req_rd_data <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            err         <= 1'b0;
        end else begin
            req_ack    <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        op_q       <= sel_wr ? OP_WR : OP_RD;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        last_grant <= sel_idx;
                        grant_idx  <= sel_idx;
                        mem_rd_req <= !sel_wr;
                        mem_wr_req <= sel_wr;
                        if (sel_rd && sel_wr) begin
                            err <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        req_rd_data <= (op_q == OP_WR) ? '0 : mem_rd_data;
                        req_ack[grant_idx] <= 1'b1;
                        state <= RESP;
                    end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
                        err         <= 1'b1;
                        req_rd_data <= '0;
                        req_ack[grant_idx] <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Directed bench for global_mem_arbiter.
// Memory side is driven by hand, one step per clock.
module tb_global_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_rd_req;
    logic [1:0]  req_wr_req;
    logic [63:0] req_addr;
    logic [63:0] req_wr_data;
    logic [1:0]  req_ack;
    logic [31:0] req_rd_data;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_ack;
    logic        busy;
    logic        grant_idx;
    logic        err;

    int checks = 0;
    int errors = 0;

    global_mem_arbiter #(
        .NUM_REQ       (2),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd_req (req_rd_req),
        .req_wr_req (req_wr_req),
        .req_addr   (req_addr),
        .req_wr_data(req_wr_data),
        .req_ack    (req_ack),
        .req_rd_data(req_rd_data),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .grant_idx  (grant_idx),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_rd_req = '0;
        req_wr_req = '0;
        mem_ack    = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Called at an IDLE cycle with the request already driven.
    task automatic txn(input int idx, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int delay,
                       input bit drop);
        logic [1:0] ack_exp;
        ack_exp = 2'b01 << idx;
        step();
        check("grant_idx", 64'(grant_idx), 64'(idx));
        check("mem_wr_req", 64'(mem_wr_req), 64'(wr));
        check("mem_rd_req", 64'(mem_rd_req), 64'(!wr));
        check("mem_addr", 64'(mem_addr), 64'(addr));
        if (wr) check("mem_wr_data", 64'(mem_wr_data), 64'(wdata));
        check("busy_issue", 64'(busy), 64'd1);
        step();
        check("pulse_len", 64'({mem_rd_req, mem_wr_req}), 64'd0);
        repeat (delay - 1) step();
        mem_ack     = 1'b1;
        mem_rd_data = rdata;
        check("ack_early", 64'(req_ack), 64'd0);
        step();
        mem_ack = 1'b0;
        check("req_ack", 64'(req_ack), 64'(ack_exp));
        check("req_rd_data", 64'(req_rd_data), wr ? 64'd0 : 64'(rdata));
        if (drop) begin
            req_rd_req[idx] = 1'b0;
            req_wr_req[idx] = 1'b0;
        end
        step();
        check("ack_len", 64'(req_ack), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst         = 1'b0;
        req_rd_req  = '0;
        req_wr_req  = '0;
        req_addr    = '0;
        req_wr_data = '0;
        mem_rd_data = '0;
        mem_ack     = 1'b0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(req_ack), 64'd0);
        check("rst_pulses", 64'({mem_rd_req, mem_wr_req}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_rdata", 64'(req_rd_data), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        rst = 1'b1;
        step();

        // single read
        req_addr[31:0] = 32'h40;
        req_rd_req     = 2'b01;
        txn(0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, 1'b1);
        step();
        check("rdata_hold", 64'(req_rd_data), 64'hDEADBEEF);

        // contention from reset, order 0,1,0,1
        do_reset();
        req_addr    = {32'h20, 32'h10};
        req_wr_data = {32'h22, 32'h11};
        req_wr_req  = 2'b11;
        txn(0, 1'b1, 32'h10, 32'h11, 32'hBAD0BAD0, 2, 1'b1);
        req_wr_req[0] = 1'b1;
        txn(1, 1'b1, 32'h20, 32'h22, 32'hBAD0BAD0, 1, 1'b1);
        req_wr_req[1] = 1'b1;
        txn(0, 1'b1, 32'h10, 32'h11, 32'hBAD0BAD0, 3, 1'b1);
        req_wr_req[0] = 1'b1;
        txn(1, 1'b1, 32'h20, 32'h22, 32'hBAD0BAD0, 2, 1'b1);
        req_wr_req = '0;

        // fairness: req 1 held, req 0 re-requests
        req_addr   = {32'h200, 32'h100};
        req_rd_req = 2'b10;
        txn(1, 1'b0, 32'h200, 32'h0, 32'h11110001, 2, 1'b0);
        req_rd_req[0] = 1'b1;
        txn(0, 1'b0, 32'h100, 32'h0, 32'h22220002, 2, 1'b1);
        req_rd_req[0] = 1'b1;
        txn(1, 1'b0, 32'h200, 32'h0, 32'h33330003, 1, 1'b0);
        txn(0, 1'b0, 32'h100, 32'h0, 32'h44440004, 2, 1'b1);
        req_rd_req = '0;

        // timeout with no memory ack
        req_addr[31:0] = 32'h300;
        req_rd_req     = 2'b01;
        step();
        check("to_pulse", 64'(mem_rd_req), 64'd1);
        repeat (5) step();
        check("to_ack_early", 64'(req_ack), 64'd0);
        check("to_err_early", 64'(err), 64'd0);
        step();
        check("to_ack", 64'(req_ack), 64'd1);
        check("to_rdata", 64'(req_rd_data), 64'd0);
        check("to_err", 64'(err), 64'd1);
        req_rd_req = '0;
        step();
        req_addr[63:32] = 32'h400;
        req_rd_req      = 2'b10;
        txn(1, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, 3, 1'b1);
        check("to_err_sticky", 64'(err), 64'd1);

        // rd+wr conflict
        do_reset();
        check("cf_err_clear", 64'(err), 64'd0);
        req_addr[31:0]    = 32'h500;
        req_wr_data[31:0] = 32'h55;
        req_rd_req        = 2'b01;
        req_wr_req        = 2'b01;
        txn(0, 1'b1, 32'h500, 32'h55, 32'hBAD0BAD0, 2, 1'b1);
        check("cf_err", 64'(err), 64'd1);

        // async reset during WAIT
        req_addr[31:0] = 32'h600;
        req_rd_req     = 2'b01;
        step();
        step();
        #1;
        rst = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_addr", 64'(mem_addr), 64'd0);
        check("ar_err", 64'(err), 64'd0);
        check("ar_ack", 64'(req_ack), 64'd0);
        req_rd_req  = '0;
        mem_ack     = 1'b1;
        mem_rd_data = 32'h99999999;
        step();
        step();
        rst = 1'b1;
        step();
        mem_ack = 1'b0;
        check("ar_late_ack", 64'(req_ack), 64'd0);
        check("ar_late_busy", 64'(busy), 64'd0);
        step();
        check("ar_late_ack2", 64'(req_ack), 64'd0);
        req_addr   = {32'h800, 32'h700};
        req_rd_req = 2'b11;
        txn(0, 1'b0, 32'h700, 32'h0, 32'h77, 2, 1'b1);
        txn(1, 1'b0, 32'h800, 32'h0, 32'h88, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
